// File: rtl/pwd_pkg.sv
// Shared types, default window/framing constants and width helpers for the
// password access controller.
package pwd_pkg;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        UNLOCKED = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    localparam int unsigned ATTEMPT_LEN_DEF = 4;
    localparam int unsigned MAX_FAIL_DEF    = 3;
    localparam int unsigned UNLOCK_CYC_DEF  = 8;
    localparam int unsigned LOCK_CYC_DEF    = 16;
    localparam int unsigned GAP_CYC_DEF     = 6;

    // Bits needed to hold values 0..n-1 (never less than one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pwd_win_timer.sv
// Loadable down-counter with a zero flag; load wins over enable and the
// count stops at zero.
module pwd_win_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero_c
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/pwd_access_ctrl.sv
// Frames serial password bits into attempts, grants a timed unlock window on
// a match and enforces a timed lockout after repeated failures.
// Optional partial-frame timeout: define PWD_FRAME_TIMEOUT_EN.
module pwd_access_ctrl
    import pwd_pkg::*;
#(
`ifdef PWD_FRAME_TIMEOUT_EN
    parameter int unsigned GAP_CYC     = GAP_CYC_DEF,
`endif
    parameter int unsigned ATTEMPT_LEN = ATTEMPT_LEN_DEF,
    parameter int unsigned MAX_FAIL    = MAX_FAIL_DEF,
    parameter int unsigned UNLOCK_CYC  = UNLOCK_CYC_DEF,
    parameter int unsigned LOCK_CYC    = LOCK_CYC_DEF,
    localparam int unsigned FCW        = cnt_w(MAX_FAIL + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           bit_valid_i,
    input  logic           match_i,
    output logic           unlock_o,
    output logic           lockout_o,
    output logic           attempt_done_o,
    output logic           attempt_ok_o,
    output logic [FCW-1:0] fail_cnt_o
);

`ifdef PWD_FRAME_TIMEOUT_EN
    localparam int unsigned TW = cnt_w(max2(max2(UNLOCK_CYC, LOCK_CYC), GAP_CYC));
`else
    localparam int unsigned TW = cnt_w(max2(UNLOCK_CYC, LOCK_CYC));
`endif
    localparam int unsigned BCW = cnt_w(ATTEMPT_LEN);

    state_t           r_state;
    state_t           w_next_state;
    logic [BCW-1:0]   r_bit_cnt;
    logic [BCW-1:0]   w_bit_cnt_n;
    logic             r_match_seen;
    logic             w_match_seen_n;
    logic [FCW-1:0]   r_fail_cnt;
    logic [FCW-1:0]   w_fail_cnt_n;
    logic             r_unlock;
    logic             r_lockout;
    logic             r_done;
    logic             r_ok;
    logic             w_done_n;
    logic             w_ok_n;
    logic             w_close;
    logic             w_success;
    logic             w_tmr_load;
    logic             w_tmr_en;
    logic [TW-1:0]    w_tmr_val;
    logic             w_tmr_zero;

    // One timer serves the unlock window, the lockout window and, while
    // armed, the inter-bit gap limit.
    pwd_win_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero_c   (w_tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ARMED;
            r_bit_cnt    <= '0;
            r_match_seen <= 1'b0;
            r_fail_cnt   <= '0;
            r_unlock     <= 1'b0;
            r_lockout    <= 1'b0;
            r_done       <= 1'b0;
            r_ok         <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_bit_cnt    <= w_bit_cnt_n;
            r_match_seen <= w_match_seen_n;
            r_fail_cnt   <= w_fail_cnt_n;
            r_unlock     <= (w_next_state == UNLOCKED);
            r_lockout    <= (w_next_state == LOCKED);
            r_done       <= w_done_n;
            r_ok         <= w_ok_n;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_bit_cnt_n    = r_bit_cnt;
        w_match_seen_n = r_match_seen;
        w_fail_cnt_n   = r_fail_cnt;
        w_done_n       = 1'b0;
        w_ok_n         = 1'b0;
        w_close        = 1'b0;
        w_success      = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_en       = 1'b0;
        w_tmr_val      = '0;

        case (r_state)
            ARMED: begin
                if (bit_valid_i) begin
                    if (r_bit_cnt == BCW'(ATTEMPT_LEN - 1)) begin
                        w_close   = 1'b1;
                        w_success = r_match_seen | match_i;
                    end else begin
                        w_bit_cnt_n    = r_bit_cnt + BCW'(1);
                        w_match_seen_n = r_match_seen | match_i;
`ifdef PWD_FRAME_TIMEOUT_EN
                        w_tmr_load = 1'b1;
                        w_tmr_val  = TW'(GAP_CYC - 1);
`endif
                    end
                end
`ifdef PWD_FRAME_TIMEOUT_EN
                // Idle inside a partial frame: expire it as a failed attempt.
                else if (r_bit_cnt != '0) begin
                    if (w_tmr_zero) begin
                        w_close = 1'b1;
                    end else begin
                        w_tmr_en = 1'b1;
                    end
                end
`endif
                if (w_close) begin
                    w_bit_cnt_n    = '0;
                    w_match_seen_n = 1'b0;
                    w_done_n       = 1'b1;
                    if (w_success) begin
                        w_ok_n       = 1'b1;
                        w_fail_cnt_n = '0;
                        w_next_state = UNLOCKED;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = TW'(UNLOCK_CYC - 1);
                    end else if (32'(r_fail_cnt) + 32'd1 >= MAX_FAIL) begin
                        w_fail_cnt_n = FCW'(MAX_FAIL);
                        w_next_state = LOCKED;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = TW'(LOCK_CYC - 1);
                    end else begin
                        w_fail_cnt_n = r_fail_cnt + FCW'(1);
                    end
                end
            end
            UNLOCKED: begin
                if (w_tmr_zero) begin
                    w_next_state = ARMED;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            LOCKED: begin
                if (w_tmr_zero) begin
                    w_next_state = ARMED;
                    w_fail_cnt_n = '0;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            default: begin
                w_next_state = ARMED;
            end
        endcase
    end

    assign unlock_o       = r_unlock;
    assign lockout_o      = r_lockout;
    assign attempt_done_o = r_done;
    assign attempt_ok_o   = r_ok;
    assign fail_cnt_o     = r_fail_cnt;

endmodule

// File: tb/tb_pwd_access_ctrl.sv
// Directed bench for pwd_access_ctrl: framing, unlock/lockout windows,
// input masking, asynchronous reset and the optional frame timeout.
module tb_pwd_access_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_valid_i;
    logic       match_i;
    logic       unlock_o;
    logic       lockout_o;
    logic       attempt_done_o;
    logic       attempt_ok_o;
    logic [1:0] fail_cnt_o;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    pwd_access_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bit_valid_i    (bit_valid_i),
        .match_i        (match_i),
        .unlock_o       (unlock_o),
        .lockout_o      (lockout_o),
        .attempt_done_o (attempt_done_o),
        .attempt_ok_o   (attempt_ok_o),
        .fail_cnt_o     (fail_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic unl, input logic lck,
                        input logic dn, input logic ok, input logic [1:0] fc);
        chk({tag, ".unlock"},  32'(unlock_o),       32'(unl));
        chk({tag, ".lockout"}, 32'(lockout_o),      32'(lck));
        chk({tag, ".done"},    32'(attempt_done_o), 32'(dn));
        chk({tag, ".ok"},      32'(attempt_ok_o),   32'(ok));
        chk({tag, ".fail"},    32'(fail_cnt_o),     32'(fc));
    endtask

    // Present one cycle of input; returns aligned to the next falling edge.
    task automatic drive(input logic bv, input logic m);
        bit_valid_i = bv;
        match_i     = m;
        @(negedge clk);
    endtask

    // Idle cycles while tallying window outputs and attempt pulses.
    task automatic idle_run(input int n, output int unl, output int lck, output int dn);
        unl = 0; lck = 0; dn = 0;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0);
            if (unlock_o) unl++;
            if (lockout_o) lck++;
            if (attempt_done_o) dn++;
        end
    endtask

    task automatic frame(input logic m_last);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, m_last);
    endtask

    int unl_c, lck_c, dn_c;

    initial begin
        rst_n       = 1'b0;
        bit_valid_i = 1'b0;
        match_i     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct code: match on the 4th bit.
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        chk("t1.no_early_done", 32'(attempt_done_o), 32'd0);
        drive(1'b1, 1'b1);
        outs("t1.close", 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
        idle_run(10, unl_c, lck_c, dn_c);
        chk("t1.unlock_rest", 32'(unl_c), 32'd7);
        chk("t1.no_lockout", 32'(lck_c), 32'd0);
        chk("t1.single_pulse", 32'(dn_c), 32'd0);

        // Two wrong frames, then a correct one.
        frame(1'b0);
        outs("t2.fail1", 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        frame(1'b0);
        outs("t2.fail2", 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        outs("t2.ok_mid_match", 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
        idle_run(10, unl_c, lck_c, dn_c);
        chk("t2.unlock_rest", 32'(unl_c), 32'd7);
        chk("t2.no_lockout", 32'(lck_c), 32'd0);

        // Three wrong frames lock out; inputs during lockout are masked.
        frame(1'b0);
        frame(1'b0);
        outs("t3.fail2", 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
        frame(1'b0);
        outs("t3.lock", 1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
        unl_c = 0; lck_c = 0; dn_c = 0;
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'(i & 1));
            if (unlock_o) unl_c++;
            if (lockout_o) lck_c++;
            if (attempt_done_o) dn_c++;
        end
        chk("t3.lock_rest", 32'(lck_c), 32'd15);
        chk("t3.lock_no_unlock", 32'(unl_c), 32'd0);
        chk("t3.lock_no_done", 32'(dn_c), 32'd0);
        chk("t3.lock_fail_hold", 32'(fail_cnt_o), 32'd3);
        drive(1'b0, 1'b0);
        outs("t3.released", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        frame(1'b1);
        outs("t3.unlock_after", 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);

        // Bits inside the unlock window are ignored.
        unl_c = 0; dn_c = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1);
            if (unlock_o) unl_c++;
            if (attempt_done_o) dn_c++;
        end
        chk("t4.masked_done", 32'(dn_c), 32'd0);
        idle_run(8, unl_c, lck_c, dn_c);
        chk("t4.window_len", 32'(unl_c), 32'd3);
        chk("t4.masked_done2", 32'(dn_c), 32'd0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        chk("t4.fresh_bit3", 32'(attempt_done_o), 32'd0);
        drive(1'b1, 1'b1);
        outs("t4.fresh_close", 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);

        // Asynchronous reset inside the unlock window.
        drive(1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1 outs("t5.async_window", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-frame restarts framing.
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        rst_n = 1'b0;
        #1 outs("t5.async_frame", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        chk("t5.no_stale_close", 32'(attempt_done_o), 32'd0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        outs("t5.restart_ok", 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
        idle_run(10, unl_c, lck_c, dn_c);
        chk("t5.unlock_rest", 32'(unl_c), 32'd7);

        // Gap inside a partial frame.
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        dn_c = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0);
            if (attempt_done_o) dn_c++;
        end
        chk("t6.gap_early", 32'(dn_c), 32'd0);
        drive(1'b0, 1'b0);
`ifdef PWD_FRAME_TIMEOUT_EN
        outs("t6.timeout", 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        drive(1'b0, 1'b0);
        chk("t6.pulse_1cyc", 32'(attempt_done_o), 32'd0);
`else
        chk("t6.no_timeout", 32'(attempt_done_o), 32'd0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        chk("t6.still_none", 32'(attempt_done_o), 32'd0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        outs("t6.frame_kept", 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pwd_access_ctrl.md
Name: pwd_access_ctrl

Overview:
- Downstream consumer of the 4-bit serial password detector.
- Frames the serial input stream into fixed-length attempts and grants a timed unlock window when the detector reports a match.
- Counts consecutive failed attempts and enforces a timed lockout after too many failures.
- Drives the door/unlock actuator and the status logic.

Parameters:
- ATTEMPT_LEN, 4: bits per attempt frame.
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout.
- UNLOCK_CYC, 8: cycles unlock_o stays high after a successful attempt.
- LOCK_CYC, 16: cycles lockout_o stays high.
- GAP_CYC, 6: idle-cycle limit inside a partial frame; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bit_valid_i  in  1  a serial password bit is presented this cycle (same bit the detector consumes).
- match_i  in  1  detector output, aligned to the bit_valid_i cycle that completes the code.
- unlock_o  out  1  registered; high during the unlock window.
- lockout_o  out  1  registered; high during lockout.
- attempt_done_o  out  1  registered 1-cycle pulse per closed attempt.
- attempt_ok_o  out  1  registered; valid with attempt_done_o; 1 = success.
- fail_cnt_o  out  $clog2(MAX_FAIL+1)  consecutive failure count.

Behaviour:
- Reset, asynchronous and active-low:
  - state=ARMED, bit_cnt=0, match_seen=0, timer=0, fail_cnt=0.
  - All outputs 0.
- States: ARMED, UNLOCKED, LOCKED.
- ARMED:
  - Each cycle with bit_valid_i, bit_cnt increments.
  - If match_i && bit_valid_i, match_seen is set.
  - match_i without bit_valid_i is ignored.
- Attempt closes when bit_valid_i && bit_cnt==ATTEMPT_LEN-1:
  - bit_cnt and match_seen clear.
  - attempt_done_o pulses on the next cycle.
  - Success = match_seen || match_i that cycle:
    - fail_cnt<=0, attempt_ok_o=1, next state UNLOCKED, timer<=UNLOCK_CYC-1.
  - Failure:
    - fail_cnt<=fail_cnt+1, attempt_ok_o=0.
    - If fail_cnt+1==MAX_FAIL: next state LOCKED, timer<=LOCK_CYC-1; fail_cnt holds MAX_FAIL.
- UNLOCKED:
  - unlock_o=1 for exactly UNLOCK_CYC cycles, starting the cycle after the closing bit.
  - bit_valid_i and match_i are ignored; no framing.
  - When timer==0, next state ARMED.
- LOCKED:
  - lockout_o=1 for exactly LOCK_CYC cycles.
  - All inputs are ignored.
  - When timer==0: next state ARMED, fail_cnt<=0.
- On return to ARMED, bit_cnt=0: the next valid bit starts a fresh frame.
- unlock_o and lockout_o are never high together.
- fail_cnt saturates at MAX_FAIL and never wraps.
- Timer width: $clog2(max(UNLOCK_CYC,LOCK_CYC)); it is a down-counter loaded on state entry.
- Reset asserted mid-window or mid-frame: outputs drop immediately (asynchronously); all state is lost.
- Gaps between bits (bit_valid_i low) do not break a frame unless the optional feature is enabled.

Optional Feature:
- Macro: PWD_FRAME_TIMEOUT_EN.
- Defined:
  - In ARMED with bit_cnt!=0, a gap counter counts cycles without bit_valid_i.
  - When it reaches GAP_CYC, the partial frame is discarded and closed as a failure: attempt_done_o pulse, attempt_ok_o=0, fail_cnt increment, lockout check as above.
  - The gap counter clears on every bit_valid_i and on frame close.
- Undefined: no gap counter; partial frames persist indefinitely.

Decomposition:
- Shared package pwd_pkg holds:
  - state enum (ARMED, UNLOCKED, LOCKED);
  - default ATTEMPT_LEN / MAX_FAIL / UNLOCK_CYC / LOCK_CYC constants;
  - helper width function for fail_cnt and timer.
- One natural sub-module, pwd_win_timer: loadable down-counter with load value, enable and zero flag. It is shared by the unlock and lockout windows (and the gap counter when enabled).

Test Plan:
- Correct code with match_i on the 4th valid bit:
  - attempt_done_o and attempt_ok_o=1 one cycle later.
  - unlock_o high for exactly 8 cycles; fail_cnt_o=0.
- Two wrong 4-bit frames then one correct frame:
  - fail_cnt_o goes 1 then 2, then resets to 0 on success.
  - unlock_o 8 cycles; lockout_o never high.
- Three wrong frames:
  - lockout_o high for exactly 16 cycles starting after the 12th bit; fail_cnt_o=3.
  - match_i pulses during lockout are ignored.
  - After lockout: fail_cnt_o=0 and a correct frame unlocks.
- Bits during UNLOCKED:
  - 4 valid bits with match_i inside the window produce no attempt_done_o and do not extend the window.
  - The following frame is counted from bit 1.
- Reset mid-frame:
  - 2 bits, then rst_n low for 1 cycle: all outputs 0 at once.
  - After release, 4 more bits with match_i on the 4th → success (the frame restarted).
- With PWD_FRAME_TIMEOUT_EN: 2 bits, then 6 idle cycles → attempt_done_o, attempt_ok_o=0, fail_cnt_o=1.
- Without PWD_FRAME_TIMEOUT_EN: the same stimulus produces no pulse.
